fifo_sync_param: RTL and testbench
==================================

# fifo_sync_param

Parametrised synchronous FIFO. It replaces the bare storage block with a complete single-clock queue:
- full, empty and programmable almost-full/almost-empty flags;
- occupancy count;
- overflow/underflow error pulses;
- selectable standard or first-word-fall-through (FWFT) read mode.

It sits between a producer and a consumer in the same clock domain, for example a serial-receive datapath feeding a packet parser.

## Interface
Parameters:
- DATA_LENGTH, 8, word width in bits (≥1)
- FIFO_DEPTH, 8, number of entries; any value ≥2, power of two not required
- MODE, FIFO_STD, read mode: FIFO_STD or FIFO_FWFT (fifo_mode_e)
- AF_THRESH, FIFO_DEPTH-1, almost_full asserts when count ≥ AF_THRESH
- AE_THRESH, 1, almost_empty asserts when count ≤ AE_THRESH

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- dataIn  in  DATA_LENGTH  write data
- write_enable  in  1  write request
- read_enable  in  1  read request
- dataOut  out  DATA_LENGTH  read data
- full  out  1  count == FIFO_DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  $clog2(FIFO_DEPTH+1)  current occupancy
- overflow  out  1  one-cycle pulse: a write was rejected
- underflow  out  1  one-cycle pulse: a read was rejected

## Operation
- Accepted write: write_enable && !full. It stores dataIn at wr_ptr and advances wr_ptr.
- Accepted read: read_enable && !empty. It advances rd_ptr.
- Pointers are binary in 0..FIFO_DEPTH-1 and wrap from FIFO_DEPTH-1 to 0.
- Count update per edge:
  - +1 for an accepted write only.
  - −1 for an accepted read only.
  - Unchanged when both are accepted, or when neither is.
- Full with write_enable and read_enable both high: the read is accepted and the write is rejected (overflow=1). Count becomes FIFO_DEPTH-1.
- Empty with both high: the write is accepted and the read is rejected (underflow=1). Count becomes 1.
- Rejected operations leave storage, pointers and count untouched.
- full, empty, almost_full and almost_empty are decoded combinationally from the registered count only, never from the request inputs.
- MODE=FIFO_STD:
  - dataOut is registered and loads mem[rd_ptr] on an accepted read.
  - Otherwise dataOut holds its previous value.
- MODE=FIFO_FWFT:
  - dataOut = mem[rd_ptr] whenever !empty. It is valid before read_enable is asserted, and read_enable acts as pop.
  - When empty, dataOut is don't-care; the bench must not check it.
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - rd_ptr=0, wr_ptr=0, count=0.
  - empty=1, full=0, almost_empty=1, almost_full=0 (given AF_THRESH ≥ 1).
  - overflow=0, underflow=0.
  - dataOut=0 in FIFO_STD mode.
- Storage contents are not reset.
- Elaboration checks: error if AF_THRESH > FIFO_DEPTH or AE_THRESH ≥ FIFO_DEPTH.

## Timing
- Write to flag update: count and flags change on the same edge that accepts the write. From the request cycle, empty deasserts 1 cycle later.
- FIFO_STD read latency: 1 cycle. Data appears on the edge that accepts the read.
- FIFO_FWFT first-word latency: 1 cycle after the accepting write edge, dataOut shows the word.
- Back-to-back reads or writes are sustained at 1 per cycle with no bubbles.
- overflow/underflow assert for exactly the cycle after the rejecting edge, then clear unless rejected again.

## Structure
- Package fifo_pkg holds:
  - typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
  - function ptr_inc(ptr, depth), the wrap-aware increment.
- Sub-module fifo_ram: FIFO_DEPTH×DATA_LENGTH array, synchronous write port, asynchronous read port, no reset.
- The top level holds the pointers, count, flag decode, error pulses and the mode-dependent dataOut register/mux.

## Test plan
- Fill/drain, DATA_LENGTH=8, FIFO_DEPTH=8, FIFO_STD:
  - Write 0x01..0x08 → full=1 and count=8 after the 8th edge.
  - Read 8 → dataOut sequence 0x01..0x08, each 1 cycle after its read; then empty=1.
- Non-power-of-2 wrap, FIFO_DEPTH=6:
  - Stream 20 words 0x10..0x23 with a read and write every cycle after a 3-word prefill → output order preserved.
  - count stays 3 throughout the concurrent phase.
  - Pointers wrap 5→0 without error.
- Boundaries:
  - Write while full with read_enable=0 → overflow pulse, count=8, contents unchanged.
  - Read while empty → underflow pulse, dataOut unchanged.
  - Both requests while full → count 8→7, overflow=1.
  - Both requests while empty → count 0→1, underflow=1.
- Thresholds, AF_THRESH=6, AE_THRESH=2:
  - almost_empty clears at count 3.
  - almost_full sets at count 6 and clears at 5.
- FWFT:
  - Write 0xA5 into an empty FIFO → dataOut=0xA5 one cycle later with read_enable=0.
  - Pop → empty=1.
- Reset mid-operation:
  - With 5 entries, assert reset between edges → count=0, empty=1 and dataOut=0 immediately, with no clock edge.
  - After release, the next read is rejected with underflow.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO.
// Provides the read-mode enum and a pointer increment that wraps at any depth.
package fifo_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  // Depth need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: DEPTH x WIDTH array, synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_ram #(
  parameter int DATA_LENGTH = 8,
  parameter int FIFO_DEPTH  = 8,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_wr_en,
  input  logic [AW-1:0]          i_wr_addr,
  input  logic [DATA_LENGTH-1:0] i_wr_dat,
  input  logic [AW-1:0]          i_rd_addr,
  output logic [DATA_LENGTH-1:0] o_rd_dat
);

  logic [DATA_LENGTH-1:0] r_mem [FIFO_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_dat;
  end

  assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with count, threshold flags, error pulses and STD/FWFT read modes.
// Writes are refused when full and reads when empty; refusals pulse overflow/underflow.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int         DATA_LENGTH = 8,
  parameter int         FIFO_DEPTH  = 8,
  parameter fifo_mode_e MODE        = FIFO_STD,
  parameter int         AF_THRESH   = FIFO_DEPTH - 1,
  parameter int         AE_THRESH   = 1,
  localparam int        CW          = $clog2(FIFO_DEPTH + 1),
  localparam int        PW          = $clog2(FIFO_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_LENGTH-1:0] dataIn,
  input  logic                   write_enable,
  input  logic                   read_enable,
  output logic [DATA_LENGTH-1:0] dataOut,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [CW-1:0]          count,
  output logic                   overflow,
  output logic                   underflow
);

  if (FIFO_DEPTH < 2 || AF_THRESH > FIFO_DEPTH || AE_THRESH >= FIFO_DEPTH) begin : g_bad_param
    $error("fifo_sync_param: illegal FIFO_DEPTH/AF_THRESH/AE_THRESH combination");
  end

  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   r_overflow;
  logic                   r_underflow;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_wr_acc;
  logic                   w_rd_acc;
  logic [DATA_LENGTH-1:0] w_rd_dat;

  // Flags come from the registered count only, never from the requests.
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = write_enable && !w_full;
  assign w_rd_acc = read_enable && !w_empty;

  fifo_ram #(
    .DATA_LENGTH(DATA_LENGTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ram (
    .i_clk    (clk),
    .i_wr_en  (w_wr_acc),
    .i_wr_addr(r_wr_ptr),
    .i_wr_dat (dataIn),
    .i_rd_addr(r_rd_ptr),
    .o_rd_dat (w_rd_dat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= PW'(ptr_inc(32'(r_wr_ptr), 32'(FIFO_DEPTH)));
      if (w_rd_acc) r_rd_ptr <= PW'(ptr_inc(32'(r_rd_ptr), 32'(FIFO_DEPTH)));
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_overflow  <= write_enable && w_full;
      r_underflow <= read_enable && w_empty;
    end
  end

  if (MODE == FIFO_STD) begin : g_std
    logic [DATA_LENGTH-1:0] r_dout;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)        r_dout <= '0;
      else if (w_rd_acc) r_dout <= w_rd_dat;
    end
    assign dataOut = r_dout;
  end else begin : g_fwft
    // Head word is shown combinationally; a read just advances past it.
    assign dataOut = w_rd_dat;
  end

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= CW'(AF_THRESH));
  assign almost_empty = (r_count <= CW'(AE_THRESH));
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench: three FIFO instances (depth-8 STD with thresholds, depth-6 STD, depth-8 FWFT).
module tb_fifo_sync_param;
  import fifo_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] a_din, a_dout;
  logic       a_wr, a_rd, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic [3:0] a_cnt;
  logic [7:0] b_din, b_dout;
  logic       b_wr, b_rd, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [2:0] b_cnt;
  logic [7:0] c_din, c_dout;
  logic       c_wr, c_rd, c_full, c_empty, c_af, c_ae, c_ovf, c_udf;
  logic [3:0] c_cnt;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];
  bit         pa = 1'b0;
  bit         pb = 1'b0;

  fifo_sync_param #(.DATA_LENGTH(8), .FIFO_DEPTH(8), .MODE(FIFO_STD), .AF_THRESH(6), .AE_THRESH(2)) u_a (
    .clk(clk), .reset(rst_n), .dataIn(a_din), .write_enable(a_wr), .read_enable(a_rd),
    .dataOut(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
    .count(a_cnt), .overflow(a_ovf), .underflow(a_udf));

  fifo_sync_param #(.DATA_LENGTH(8), .FIFO_DEPTH(6), .MODE(FIFO_STD)) u_b (
    .clk(clk), .reset(rst_n), .dataIn(b_din), .write_enable(b_wr), .read_enable(b_rd),
    .dataOut(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
    .count(b_cnt), .overflow(b_ovf), .underflow(b_udf));

  fifo_sync_param #(.DATA_LENGTH(8), .FIFO_DEPTH(8), .MODE(FIFO_FWFT)) u_c (
    .clk(clk), .reset(rst_n), .dataIn(c_din), .write_enable(c_wr), .read_enable(c_rd),
    .dataOut(c_dout), .full(c_full), .empty(c_empty), .almost_full(c_af), .almost_empty(c_ae),
    .count(c_cnt), .overflow(c_ovf), .underflow(c_udf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic no_expect(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: output presented with no queued expectation at %0t", nm, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs change at posedge+1, so at the falling edge they are the ones the next rising edge will use.
  always @(negedge clk) begin
    if (pa) begin
      if (qa.size() == 0) no_expect("a_dout");
      else chk("a_dout", 32'(a_dout), 32'(qa.pop_front()));
    end
    pa = a_rd;
    if (pb) begin
      if (qb.size() == 0) no_expect("b_dout");
      else chk("b_dout", 32'(b_dout), 32'(qb.pop_front()));
    end
    pb = b_rd;
    if (c_rd && !c_empty) begin
      if (qc.size() == 0) no_expect("c_dout");
      else chk("c_dout", 32'(c_dout), 32'(qc.pop_front()));
    end
  end

  initial begin
    rst_n = 1'b0;
    {a_wr, a_rd, b_wr, b_rd, c_wr, c_rd} = '0;
    a_din = '0; b_din = '0; c_din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 32'(a_empty), 1);
    chk("rst_full", 32'(a_full), 0);
    chk("rst_ae", 32'(a_ae), 1);
    chk("rst_af", 32'(a_af), 0);
    chk("rst_count", 32'(a_cnt), 0);
    chk("rst_ovf_udf", 32'({a_ovf, a_udf}), 0);
    chk("rst_dout", 32'(a_dout), 0);
    chk("rst_c_empty", 32'(c_empty), 1);
    rst_n = 1'b1;
    tick();

    // Fill 0x01..0x08, watching thresholds AF=6 / AE=2
    for (int i = 1; i <= 8; i++) begin
      a_wr = 1'b1; a_din = 8'(i);
      tick();
      chk("fill_count", 32'(a_cnt), 32'(i));
      chk("fill_empty", 32'(a_empty), 0);
      chk("fill_full", 32'(a_full), (i == 8) ? 1 : 0);
      chk("fill_ae", 32'(a_ae), (i <= 2) ? 1 : 0);
      chk("fill_af", 32'(a_af), (i >= 6) ? 1 : 0);
    end

    a_din = 8'hFF;
    tick();
    chk("ovf_pulse", 32'(a_ovf), 1);
    chk("ovf_count", 32'(a_cnt), 8);
    a_wr = 1'b0;
    tick();
    chk("ovf_clear", 32'(a_ovf), 0);

    // Both requests while full: read wins, write refused
    a_wr = 1'b1; a_din = 8'hEE; a_rd = 1'b1; qa.push_back(8'h01);
    tick();
    chk("full_both_count", 32'(a_cnt), 7);
    chk("full_both_ovf", 32'(a_ovf), 1);
    a_wr = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      qa.push_back(8'(i));
      tick();
      chk("drain_count", 32'(a_cnt), 32'(8 - i));
      chk("drain_af", 32'(a_af), (8 - i >= 6) ? 1 : 0);
      chk("drain_empty", 32'(a_empty), (i == 8) ? 1 : 0);
      if (i == 2) chk("drain_ovf_clear", 32'(a_ovf), 0);
    end

    qa.push_back(8'h08);
    tick();
    chk("udf_pulse", 32'(a_udf), 1);
    chk("udf_count", 32'(a_cnt), 0);

    // Both requests while empty: write wins, read refused, dataOut held
    a_wr = 1'b1; a_din = 8'h33; qa.push_back(8'h08);
    tick();
    chk("empty_both_count", 32'(a_cnt), 1);
    chk("empty_both_udf", 32'(a_udf), 1);
    a_wr = 1'b0; qa.push_back(8'h33);
    tick();
    chk("pop_33_count", 32'(a_cnt), 0);
    chk("pop_33_udf", 32'(a_udf), 0);
    a_rd = 1'b0;

    for (int i = 0; i < 5; i++) begin
      a_wr = 1'b1; a_din = 8'(8'h40 + i);
      tick();
    end
    a_wr = 1'b0;
    chk("pre_rst_count", 32'(a_cnt), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(a_cnt), 0);
    chk("async_rst_empty", 32'(a_empty), 1);
    chk("async_rst_dout", 32'(a_dout), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    a_rd = 1'b1; qa.push_back(8'h00);
    tick();
    chk("post_rst_udf", 32'(a_udf), 1);
    chk("post_rst_count", 32'(a_cnt), 0);
    a_rd = 1'b0;
    tick();

    // Depth 6: prefill 3, then 17 concurrent cycles, then drain
    for (int i = 0; i < 3; i++) begin
      b_wr = 1'b1; b_din = 8'(8'h10 + i);
      tick();
    end
    chk("b_prefill_count", 32'(b_cnt), 3);
    for (int i = 0; i < 17; i++) begin
      b_wr = 1'b1; b_din = 8'(8'h13 + i); b_rd = 1'b1; qb.push_back(8'(8'h10 + i));
      tick();
      chk("b_stream_count", 32'(b_cnt), 3);
      chk("b_stream_err", 32'({b_ovf, b_udf}), 0);
    end
    b_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      qb.push_back(8'(8'h21 + i));
      tick();
    end
    b_rd = 1'b0;
    chk("b_drain_empty", 32'(b_empty), 1);
    tick();

    // FWFT: head word visible before any read
    c_wr = 1'b1; c_din = 8'hA5;
    tick();
    c_wr = 1'b0;
    chk("fwft_empty", 32'(c_empty), 0);
    chk("fwft_first_word", 32'(c_dout), 32'h A5);
    tick();
    chk("fwft_hold", 32'(c_dout), 32'h A5);
    c_rd = 1'b1; qc.push_back(8'hA5);
    tick();
    c_rd = 1'b0;
    chk("fwft_pop_empty", 32'(c_empty), 1);
    for (int i = 0; i < 3; i++) begin
      c_wr = 1'b1; c_din = 8'(8'hB1 + i);
      tick();
    end
    c_din = 8'hB4; c_rd = 1'b1; qc.push_back(8'hB1);
    tick();
    c_wr = 1'b0;
    chk("fwft_both_count", 32'(c_cnt), 3);
    for (int i = 0; i < 3; i++) begin
      qc.push_back(8'(8'hB2 + i));
      tick();
    end
    c_rd = 1'b0;
    chk("fwft_drain_empty", 32'(c_empty), 1);

    repeat (2) tick();
    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);
    chk("qc_drained", 32'(qc.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
